// File: rtl/stepper_move_controller.sv
// rtl/stepper_move_controller.sv - hardware-paced 4-phase stepper move sequencer
// Accepts a signed step count and per-step delay, steps the coils, tracks position, pulses done.
module stepper_move_controller #(
  parameter int DELAY_WIDTH = 20,
  parameter int POS_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [7:0]             cmd_steps,
  input  logic [DELAY_WIDTH-1:0] cmd_delay,
  input  logic                   abort,
  output logic [3:0]             stepper_signals,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             steps_remaining,
  output logic [POS_WIDTH-1:0]   position
);

  typedef enum logic [1:0] {IDLE, WAIT, STEP, DONE} state_t;

  state_t                 state;
  logic [1:0]             phase_idx;
  logic                   dir;
  logic [DELAY_WIDTH-1:0] reload;
  logic [DELAY_WIDTH-1:0] cnt;

  logic [1:0]             next_idx;
  logic [7:0]             cmd_mag;
  logic [DELAY_WIDTH-1:0] cmd_reload;

  function automatic logic [3:0] phase_of(input logic [1:0] idx);
    case (idx)
      2'd0:    phase_of = 4'b0011;
      2'd1:    phase_of = 4'b0110;
      2'd2:    phase_of = 4'b1100;
      default: phase_of = 4'b1001;
    endcase
  endfunction

  // -128 negates to 8'h80, which reads correctly as an unsigned 128.
  always_comb begin
    next_idx   = dir ? phase_idx - 2'd1 : phase_idx + 2'd1;
    cmd_mag    = cmd_steps[7] ? (~cmd_steps + 8'd1) : cmd_steps;
    cmd_reload = (cmd_delay < DELAY_WIDTH'(2)) ? '0 : cmd_delay - DELAY_WIDTH'(2);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      phase_idx       <= 2'd0;
      stepper_signals <= 4'b0011;
      position        <= '0;
      steps_remaining <= 8'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
      cmd_ready       <= 1'b1;
      dir             <= 1'b0;
      reload          <= '0;
      cnt             <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            dir             <= cmd_steps[7];
            steps_remaining <= cmd_mag;
            reload          <= cmd_reload;
            cmd_ready       <= 1'b0;
            if (cmd_steps == 8'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              cnt   <= cmd_reload;
              state <= WAIT;
              busy  <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (abort) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (cnt != '0) begin
            cnt <= cnt - DELAY_WIDTH'(1);
          end else begin
            state <= STEP;
          end
        end
        STEP: begin
          // Abort wins over the step: nothing moves on this edge.
          if (abort) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            phase_idx       <= next_idx;
            stepper_signals <= phase_of(next_idx);
            position        <= dir ? position - POS_WIDTH'(1) : position + POS_WIDTH'(1);
            steps_remaining <= steps_remaining - 8'd1;
            if (steps_remaining == 8'd1) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              cnt   <= reload;
              state <= WAIT;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_move_controller.sv
// tb/tb_stepper_move_controller.sv - directed-vector bench for stepper_move_controller
module tb_stepper_move_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_steps;
  logic [19:0] cmd_delay;
  logic        abort;
  logic [3:0]  stepper_signals;
  logic        busy;
  logic        done;
  logic [7:0]  steps_remaining;
  logic [15:0] position;

  int n_vec = 0;
  int n_err = 0;

  stepper_move_controller #(.DELAY_WIDTH(20), .POS_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_delay(cmd_delay), .abort(abort),
    .stepper_signals(stepper_signals), .busy(busy), .done(done),
    .steps_remaining(steps_remaining), .position(position)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] steps, input logic [19:0] dly);
    cmd_steps = steps;
    cmd_delay = dly;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Edges after the accept edge until done is seen, capped at bound.
  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
  endtask

  int n;
  int n_acc;
  int n_done;

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_steps = 8'd0; cmd_delay = 20'd0; abort = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    check("rst_sig", stepper_signals, 4'b0011);
    check("rst_pos", position, 16'd0);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);

    // +3 steps, period 4
    accept(8'd3, 20'd4);
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k <= 12) check("fwd_done", done, (k == 12));
      if (k == 4)  check("fwd_sig4", stepper_signals, 4'b0110);
      if (k == 8)  check("fwd_sig8", stepper_signals, 4'b1100);
      if (k == 12) check("fwd_sig12", stepper_signals, 4'b1001);
      if (k == 13) begin
        check("fwd_pos", position, 16'd3);
        check("fwd_rem", steps_remaining, 8'd0);
        check("fwd_ready", cmd_ready, 1'b1);
      end
    end

    // -2 steps, delay 0 treated as period 2
    accept(8'hFE, 20'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("rev_done", done, (k == 4));
      if (k == 2) check("rev_sig2", stepper_signals, 4'b1100);
      if (k == 4) begin
        check("rev_sig4", stepper_signals, 4'b0110);
        check("rev_pos", position, 16'd1);
      end
    end
    tick();

    // -128 steps, period 2
    accept(8'h80, 20'd2);
    wait_done(400, n);
    check("m128_len", n, 256);
    check("m128_pos", position, 16'hFF81);
    check("m128_sig", stepper_signals, 4'b0110);
    check("m128_rem", steps_remaining, 8'd0);
    tick();

    // zero-length move
    accept(8'd0, 20'd100);
    check("zero_done", done, 1'b1);
    check("zero_busy", busy, 1'b0);
    tick();
    check("zero_ready", cmd_ready, 1'b1);
    check("zero_done_off", done, 1'b0);
    check("zero_pos", position, 16'hFF81);
    check("zero_sig", stepper_signals, 4'b0110);

    // cmd_valid held throughout a +2 move
    cmd_steps = 8'd2; cmd_delay = 20'd2; cmd_valid = 1'b1;
    n_acc = 0;
    for (int k = 0; k < 20; k++) begin
      if (cmd_valid && cmd_ready) n_acc++;
      tick();
      if (done) begin
        cmd_valid = 1'b0;
        break;
      end
    end
    check("hold_accepts", n_acc, 1);
    check("hold_pos", position, 16'hFF83);
    check("hold_sig", stepper_signals, 4'b1001);
    tick();
    check("hold_ready", cmd_ready, 1'b1);

    // abort in the first WAIT after the first phase change
    accept(8'd5, 20'd3);
    tick(); tick(); tick();
    check("ab_sig1", stepper_signals, 4'b0011);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_done", done, 1'b1);
    check("ab_pos", position, 16'hFF84);
    check("ab_rem", steps_remaining, 8'd4);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("ab_sig_hold", stepper_signals, 4'b0011);
    end

    // abort coincident with a STEP cycle
    accept(8'd2, 20'd2);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abs_done", done, 1'b1);
    check("abs_pos", position, 16'hFF84);
    check("abs_rem", steps_remaining, 8'd2);
    check("abs_sig", stepper_signals, 4'b0011);
    tick();

    // abort together with cmd_valid in IDLE still accepts
    abort = 1'b1;
    accept(8'd1, 20'd2);
    abort = 1'b0;
    check("abi_busy", busy, 1'b1);
    wait_done(20, n);
    check("abi_len", n, 2);
    check("abi_pos", position, 16'hFF85);
    check("abi_sig", stepper_signals, 4'b0110);
    tick();

    // reset mid-move
    accept(8'd10, 20'd2);
    n_done = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (done) n_done++;
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mr_sig", stepper_signals, 4'b0011);
    check("mr_pos", position, 16'd0);
    check("mr_busy", busy, 1'b0);
    check("mr_ready", cmd_ready, 1'b1);
    check("mr_rem", steps_remaining, 8'd0);
    for (int k = 0; k < 3; k++) begin
      if (done) n_done++;
      tick();
    end
    check("mr_no_done", n_done, 0);
    accept(8'd1, 20'd2);
    wait_done(20, n);
    check("mr_new_len", n, 2);
    check("mr_new_pos", position, 16'd1);
    check("mr_new_sig", stepper_signals, 4'b0110);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
